// File: rtl/frame_tap_packer_if.sv
// Stream-side bundle for frame_tap_packer: per-channel pixel inputs, packed
// output word handshake, channel select and frame-done status.
interface frame_tap_packer_if #(
    parameter int channels_p       = 5,
    parameter int unpacked_width_p = 1,
    parameter int packed_num_p     = 8,
    parameter int sel_w_p          = $clog2(channels_p)
);
    logic [sel_w_p-1:0]                         sel_i;
    logic [channels_p-1:0]                      valid_i;
    logic [channels_p*unpacked_width_p-1:0]     data_i;
    logic [channels_p-1:0]                      ready_o;
    logic                                       valid_o;
    logic                                       ready_i;
    logic [unpacked_width_p*packed_num_p-1:0]   packed_o;
    logic [sel_w_p-1:0]                         sel_o;
    logic                                       frame_done_o;

    modport slave (
        input  sel_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, packed_o, sel_o, frame_done_o
    );

    modport master (
        output sel_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, packed_o, sel_o, frame_done_o
    );
endinterface

// File: rtl/frame_tap_packer.sv
// Taps one of several pixel streams, packs its pixels into fixed-width words
// and flushes a zero-padded partial word at every frame end.
module frame_tap_packer #(
    parameter int channels_p       = 5,
    parameter int unpacked_width_p = 1,
    parameter int packed_num_p     = 8,
    parameter int frame_px_p       = 76800,
    parameter int sel_w_p          = $clog2(channels_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    frame_tap_packer_if.slave   bus
);
    localparam int w_lp      = unpacked_width_p;
    localparam int word_w_lp = unpacked_width_p * packed_num_p;
    localparam int slot_w_lp = $clog2(packed_num_p);
    localparam int pix_w_lp  = (frame_px_p > 1) ? $clog2(frame_px_p) : 1;

    logic [sel_w_p-1:0]   act_q,   act_d;
    logic [pix_w_lp-1:0]  pix_q,   pix_d;
    logic [slot_w_lp-1:0] slot_q,  slot_d;
    logic [word_w_lp-1:0] acc_q,   acc_d;
    logic [word_w_lp-1:0] out_q,   out_d;
    logic                 valid_q, valid_d;
    logic                 done_q,  done_d;

    logic                 sel_valid;
    logic [w_lp-1:0]      sel_data;
    logic [word_w_lp-1:0] word;
    logic                 last_px;
    logic                 completing;
    logic                 stall;
    logic                 accept;
    logic                 sel_legal;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int c = 0; c < channels_p; c++) begin
            if (act_q == sel_w_p'(c)) begin
                sel_valid = bus.valid_i[c];
                sel_data  = bus.data_i[c*w_lp +: w_lp];
            end
        end
    end

    assign last_px    = (pix_q == pix_w_lp'(frame_px_p - 1));
    assign completing = (slot_q == slot_w_lp'(packed_num_p - 1)) || last_px;
    // Only a word-completing accept needs the output register free.
    assign stall      = completing && valid_q && !bus.ready_i;
    assign accept     = sel_valid && !stall;
    assign sel_legal  = ({1'b0, bus.sel_i} < (sel_w_p + 1)'(channels_p));

    always_comb begin
        for (int c = 0; c < channels_p; c++) begin
            bus.ready_o[c] = (act_q == sel_w_p'(c)) ? !stall : 1'b1;
        end
    end

    always_comb begin
        word = acc_q;
        for (int s = 0; s < packed_num_p; s++) begin
            if (slot_q == slot_w_lp'(s)) begin
                word[s*w_lp +: w_lp] = sel_data;
            end
        end
    end

    always_comb begin
        act_d   = act_q;
        pix_d   = pix_q;
        slot_d  = slot_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (completing) begin
                // Unfilled slots of a flushed partial word stay zero because acc restarts empty.
                out_d   = word;
                valid_d = 1'b1;
                acc_d   = '0;
                slot_d  = '0;
            end else begin
                acc_d   = word;
                slot_d  = slot_q + slot_w_lp'(1);
            end

            if (last_px) begin
                pix_d  = '0;
                done_d = 1'b1;
                if (sel_legal) begin
                    act_d = bus.sel_i;
                end
            end else begin
                pix_d = pix_q + pix_w_lp'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            act_q   <= '0;
            pix_q   <= '0;
            slot_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            act_q   <= act_d;
            pix_q   <= pix_d;
            slot_q  <= slot_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.packed_o     = out_q;
    assign bus.sel_o        = act_q;
    assign bus.frame_done_o = done_q;
endmodule

// File: doc/frame_tap_packer.md
FRAME_TAP_PACKER -- requirements
Module: frame_tap_packer

Interface
REQ-001 Parameter channels_p, default 5, number of selectable pixel streams (legal range 2..8).
REQ-002 Parameter unpacked_width_p, default 1, bits per pixel on each stream.
REQ-003 Parameter packed_num_p, default 8, pixels per output word (legal range 2..16).
REQ-004 Parameter frame_px_p, default 76800, pixels per frame (320x240); need not be a multiple of packed_num_p.
REQ-005 clk_i  input  1  single clock for all logic.
REQ-006 reset_i  input  1  reset, asynchronous and active-high.
REQ-007 sel_i  input  $clog2(channels_p)  requested channel; the block applies it only at frame boundaries.
REQ-008 valid_i  input  channels_p  per-channel pixel valid.
REQ-009 data_i  input  channels_p*unpacked_width_p  per-channel pixel data; channel c occupies bits [c*unpacked_width_p +: unpacked_width_p].
REQ-010 ready_o  output  channels_p  per-channel ready.
REQ-011 valid_o  output  1  packed word valid.
REQ-012 ready_i  input  1  downstream ready.
REQ-013 packed_o  output  unpacked_width_p*packed_num_p  packed word.
REQ-014 sel_o  output  $clog2(channels_p)  currently active channel.
REQ-015 frame_done_o  output  1  one-cycle pulse marking frame completion.

Function
REQ-016 Active channel register act_q SHALL select which channel's pixels are packed; sel_o = act_q.
REQ-017 Unselected channels SHALL see ready_o[c]=1 at all times (their pixels are drained and discarded, never stalling upstream).
REQ-018 Selected channel pixel accept = valid_i[act_q] & ready_o[act_q].
REQ-019 ready_o[act_q] SHALL be 1 unless the accept would complete a word (slot==packed_num_p-1 or last pixel of frame) while valid_o=1 and ready_i=0.
REQ-020 Packing order: first accepted pixel of a word in bits [unpacked_width_p-1:0], ascending thereafter.
REQ-021 On the completing accept, the full word SHALL be loaded into the output register and valid_o asserted the next cycle (latency 1 cycle from last pixel to valid_o).
REQ-022 valid_o SHALL stay high, and packed_o stable, until the cycle valid_o & ready_i; a simultaneous load and handshake SHALL replace the word with valid_o held at 1.
REQ-023 Pixel counter pix_q counts accepts 0..frame_px_p-1 and wraps to 0 on the last pixel of the frame; slot counter slot_q wraps to 0 on every word completion.
REQ-024 Frame end with a partial word: word SHALL be flushed with unfilled slots zero, and slot_q reset to 0.
REQ-025 On the last-pixel accept: frame_done_o=1 for the following cycle only, and act_q loads sel_i if sel_i < channels_p, otherwise keeps its value.
REQ-026 sel_i changes mid-frame SHALL have no effect until the frame boundary.
REQ-027 Data from non-selected channels SHALL never appear in packed_o.

Reset
REQ-028 While reset_i=1, asynchronously: act_q=0, pix_q=0, slot_q=0, accumulator=0, packed_o=0, valid_o=0, frame_done_o=0.
REQ-029 Reset asserted mid-frame SHALL discard any partial word and any unsent word; the first accept after release is pixel 0, slot 0 of a new frame on channel 0.

Verification (channels_p=2, unpacked_width_p=1, packed_num_p=4, frame_px_p=6)
REQ-030 Channel 0 streams 1,0,1,1 with ready_i=1 -> packed_o=4'b1101, valid_o one cycle after 4th accept.
REQ-031 Continue with pixels 1,1 (end of frame) -> flushed packed_o=4'b0011, frame_done_o pulses one cycle, pix_q=0.
REQ-032 sel_i=1 raised at pixel 2 -> sel_o stays 0 until the frame's 6th accept, then 1; next frame packs only channel 1 data while ready_o[0]=1 throughout.
REQ-033 ready_i=0 with a word pending and slot_q=3 -> ready_o[act]=0, no pixel lost; ready_i=1 -> handshake, next word loads with no bubble.
REQ-034 sel_i=3 (out of range, 2-bit port padded for the test) at frame end -> act_q unchanged.
REQ-035 reset_i pulsed asynchronously after 2 accepts -> valid_o=0 immediately, next word built from the 4 post-reset pixels only, sel_o=0.
